multicycle_controller: RTL and testbench

Control FSM for the team's multi-cycle RV32I core. It sits on the other side of the datapath's control interface. It consumes the opcode, funct3 and funct7 fields and the ALU flags Zero, blt and bge that the datapath exports. From these it sequences every instruction through fetch, decode, execute, memory and writeback states, producing the per-cycle select and write-enable strobes. The ALU and immediate encodings are the core's existing ones, so the block drops onto the shared-memory multi-cycle datapath without translation.

---
 rtl/multicycle_controller_if.sv | 50 +++++
 rtl/multicycle_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Control bundle between the multi-cycle RV32I datapath and its controller.
//
// Datapath -> controller:
//   op[6:0], funct3[2:0], funct7[6:0]   decoded instruction fields
//   Zero, blt, bge                      ALU flags
// Controller -> datapath:
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite        strobes / selects
//   ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0]          mux selects
//   ALUControl[2:0], ImmSrc[2:0]                        ALU / immediate select
//   done                                                last cycle of instruction
//   illegal                                             illegal-instruction flag
//
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       blt;
  logic       bge;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7, Zero, blt, bge,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, done, illegal
  );

  modport slave (
    output op, funct3, funct7, Zero, blt, bge,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the multi-cycle RV32I core. Sequences each instruction
// through fetch / decode / execute / memory / writeback and produces the
// per-cycle select and write-enable strobes for the shared-memory datapath.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous, active-high reset
//   bus   multicycle_controller_if.master
//           in : op, funct3, funct7, Zero, blt, bge
//           out: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
//                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, done, illegal
//
// Configuration macro:
//   MC_CTRL_ILLEGAL_EN  defined   : undecoded op / unsupported funct3 enters
//                                   HALT (illegal=1) until rst.
//                       undefined : such instructions retire from DECODE as a
//                                   2-cycle NOP with done=1; illegal is 0.
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
    S_LUI, S_HALT
  } state_t;

  state_t state, state_next;

  // Field decode shared by DECODE (legality) and EXEC/BRANCH (strobes).
  logic [2:0] alu_dec;
  logic       alu_ok;
  logic       br_taken;
  logic       br_ok;
  logic       decode_bad;     // instruction takes the illegal path

  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    alu_dec = ALU_ADD;
    alu_ok  = 1'b1;
    unique case (bus.funct3)
      3'b000:  alu_dec = (bus.op == OP_R && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_ok  = 1'b0;
    endcase

    br_taken = 1'b0;
    br_ok    = 1'b1;
    unique case (bus.funct3)
      3'b000:  br_taken = bus.Zero;
      3'b001:  br_taken = ~bus.Zero;
      3'b100:  br_taken = bus.blt;
      3'b101:  br_taken = bus.bge;
      default: br_ok    = 1'b0;
    endcase

    unique case (bus.op)
      OP_LW, OP_SW, OP_JAL, OP_JALR, OP_LUI: decode_bad = 1'b0;
      OP_R, OP_I:                            decode_bad = ~alu_ok;
      OP_BR:                                 decode_bad = ~br_ok;
      default:                               decode_bad = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.ImmSrc     = IMM_I;
    bus.done       = 1'b0;
    bus.illegal    = 1'b0;

    unique case (state)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
        state_next    = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC+imm into ALUOut for branch / jal targets.
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        if (decode_bad) begin
`ifdef MC_CTRL_ILLEGAL_EN
          state_next = S_HALT;
`else
          bus.done   = 1'b1;
          state_next = S_FETCH;
`endif
        end else begin
          unique case (bus.op)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_R:         state_next = S_EXECR;
            OP_I:         state_next = S_EXECI;
            OP_BR:        state_next = S_BRANCH;
            OP_JAL:       state_next = S_JAL;
            OP_JALR:      state_next = S_JALR1;
            default:      state_next = S_LUI;
          endcase
        end
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (bus.op == OP_SW) ? IMM_S : IMM_I;
        state_next  = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.done      = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.done     = 1'b1;
        state_next   = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_dec;
        state_next     = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dec;
        state_next     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.done     = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        // Flags are only consulted here; ALUOut already holds the target.
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = ALU_SUB;
        bus.PCWrite    = br_taken;
        bus.done       = 1'b1;
        state_next     = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // PC <- ALUOut (target) while ALU forms OldPC+4 for the link write.
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_next  = S_ALUWB;
      end
      S_JALR1: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_next  = S_JALR2;
      end
      S_LUI: begin
        bus.ImmSrc    = IMM_U;
        bus.ResultSrc = 2'b11;
        bus.RegWrite  = 1'b1;
        bus.done      = 1'b1;
        state_next    = S_FETCH;
      end
      S_HALT: begin
        bus.illegal = 1'b1;
        state_next  = S_HALT;
      end
      default: state_next = S_FETCH;
    endcase

    // During reset present FETCH selects with every write strobe held off,
    // so an aborted instruction cannot commit anything in the rst cycle.
    if (rst) begin
      bus.PCWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = 2'b10;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b10;
      bus.ALUControl = ALU_ADD;
      bus.ImmSrc     = IMM_I;
      bus.done       = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. For each instruction the
// expected per-cycle control vectors are queued, then popped and compared
// against the DUT one cycle at a time. Build with +define+MC_CTRL_ILLEGAL_EN
// to exercise the HALT behaviour.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
    logic       done;
    logic       illegal;
  } ctrl_t;

  logic clk;
  logic rst;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  ctrl_t sb[$];
  ctrl_t obs;

  assign obs = '{bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                 bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                 bus.ALUControl, bus.ImmSrc, bus.done, bus.illegal};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t v(input logic pcw, adr, memw, irw, regw,
                              input logic [1:0] rs, sa, sb_,
                              input logic [2:0] alu, imm,
                              input logic dn, ill);
    return '{pcw, adr, memw, irw, regw, rs, sa, sb_, alu, imm, dn, ill};
  endfunction

  // Expected vectors, written straight from the state table.
  function automatic ctrl_t fetch_v();  return v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0); endfunction
  function automatic ctrl_t rstf_v();   return v(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0); endfunction
  function automatic ctrl_t decode_v(input logic jal, input logic dn);
    return v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000, jal ? 3'b100 : 3'b010, dn,0);
  endfunction
  function automatic ctrl_t aluwb_v();  return v(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,1,0); endfunction
  function automatic ctrl_t jump_v();   return v(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000,0,0); endfunction
  function automatic ctrl_t halt_v();   return v(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,1); endfunction

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // Called just after a negedge in FETCH. Flags start inverted and take
  // their real value only from the third cycle, so a branch must decide
  // purely on what it sees in BRANCH.
  task automatic run(input string name, input logic [6:0] o,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic z, input logic l, input logic g);
    int    idx = 0;
    ctrl_t exp;
    bus.op = o; bus.funct3 = f3; bus.funct7 = f7;
    bus.Zero = ~z; bus.blt = ~l; bus.bge = ~g;
    while (sb.size() > 0) begin
      if (idx == 2) begin
        bus.Zero = z; bus.blt = l; bus.bge = g;
      end
      #1;
      exp = sb.pop_front();
      check($sformatf("%s c%0d", name, idx), 32'(obs), 32'(exp));
      @(negedge clk);
      idx++;
    end
  endtask

  task automatic alu_instr(input string name, input logic [6:0] o,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] alu);
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 0));
    if (o == OP_R) sb.push_back(v(0,0,0,0,0,2'b00,2'b10,2'b00,alu,3'b000,0,0));
    else           sb.push_back(v(0,0,0,0,0,2'b00,2'b10,2'b01,alu,3'b000,0,0));
    sb.push_back(aluwb_v());
    run(name, o, f3, f7, 0, 0, 0);
  endtask

  // funct3 / predicate table for branches.
  logic [2:0] br_f3 [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic taken;
    rst = 1'b1;
    bus.op = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.Zero = 1'b0; bus.blt = 1'b0; bus.bge = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("reset_hold", 32'(obs), 32'(rstf_v()));
    rst = 1'b0;

    // R / I ALU operations.
    alu_instr("add",  OP_R, 3'b000, 7'b0000000, 3'b000);
    alu_instr("sub",  OP_R, 3'b000, 7'b0100000, 3'b001);
    alu_instr("slt",  OP_R, 3'b010, 7'b0000000, 3'b101);
    alu_instr("xor",  OP_R, 3'b100, 7'b0000000, 3'b111);
    alu_instr("or",   OP_R, 3'b110, 7'b0000000, 3'b011);
    alu_instr("and",  OP_R, 3'b111, 7'b0000000, 3'b010);
    alu_instr("addi", OP_I, 3'b000, 7'b0100000, 3'b000);
    alu_instr("andi", OP_I, 3'b111, 7'b0000000, 3'b010);

    // lw: 5 cycles.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 0));
    sb.push_back(v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
    sb.push_back(v(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
    sb.push_back(v(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,1,0));
    run("lw", OP_LW, 3'b010, 7'b0, 0, 0, 0);

    // sw: 4 cycles.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 0));
    sb.push_back(v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0));
    sb.push_back(v(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,0));
    run("sw", OP_SW, 3'b010, 7'b0, 0, 0, 0);

    // Branches: each funct3 with its flag at 0 and 1.
    for (int i = 0; i < 4; i++) begin
      for (int f = 0; f < 2; f++) begin
        logic fl;
        fl = f[0];
        unique case (i)
          0: taken = fl;
          1: taken = ~fl;
          default: taken = fl;
        endcase
        sb.push_back(fetch_v());
        sb.push_back(decode_v(0, 0));
        sb.push_back(v(taken,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,1,0));
        run($sformatf("br f3=%b flag=%0d", br_f3[i], f), OP_BR, br_f3[i], 7'b0,
            (i < 2) ? fl : 1'b0, (i == 2) ? fl : 1'b0, (i == 3) ? fl : 1'b0);
      end
    end

    // jal: 4 cycles.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(1, 0));
    sb.push_back(jump_v());
    sb.push_back(aluwb_v());
    run("jal", OP_JAL, 3'b000, 7'b0, 0, 0, 0);

    // jalr: 5 cycles.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 0));
    sb.push_back(v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
    sb.push_back(jump_v());
    sb.push_back(aluwb_v());
    run("jalr", OP_JALR, 3'b000, 7'b0, 0, 0, 0);

    // lui: 3 cycles.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 0));
    sb.push_back(v(0,0,0,0,1,2'b11,2'b00,2'b00,3'b000,3'b011,1,0));
    run("lui", OP_LUI, 3'b000, 7'b0, 0, 0, 0);

    // rst raised in MEMWRITE: no write that cycle, FETCH next.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 0));
    sb.push_back(v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0));
    run("sw_abort", OP_SW, 3'b010, 7'b0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_memwrite MemWrite", 32'(bus.MemWrite), 32'd0);
    check("rst_memwrite done",     32'(bus.done),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_memwrite next", 32'(obs), 32'(fetch_v()));

    // rst raised in FETCH: PC/IR loads held off for two cycles.
    rst = 1'b1;
    #1 check("rst_fetch c0", 32'(obs), 32'(rstf_v()));
    @(negedge clk);
    #1 check("rst_fetch c1", 32'(obs), 32'(rstf_v()));
    rst = 1'b0;
    alu_instr("add_after_rst", OP_R, 3'b000, 7'b0000000, 3'b000);

`ifdef MC_CTRL_ILLEGAL_EN
    // Undecoded opcode: HALT with illegal held.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 0));
    for (int i = 0; i < 10; i++) sb.push_back(halt_v());
    run("illegal_op", 7'b1111111, 3'b000, 7'b0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("halt_rst_clear", 32'(obs), 32'(fetch_v()));
`else
    // Illegal paths retire as a 2-cycle NOP; the following FETCH check
    // confirms the return.
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 1));
    run("illegal_op", 7'b1111111, 3'b000, 7'b0, 0, 0, 0);
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 1));
    run("illegal_br_f3", OP_BR, 3'b010, 7'b0, 0, 0, 0);
    sb.push_back(fetch_v());
    sb.push_back(decode_v(0, 1));
    run("illegal_r_f3", OP_R, 3'b001, 7'b0, 0, 0, 0);
    check("illegal_tied", 32'(bus.illegal), 32'd0);
`endif
    alu_instr("add_final", OP_R, 3'b000, 7'b0000000, 3'b000);
    #1 check("final_fetch", 32'(obs), 32'(fetch_v()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
